// File: rtl/lit_base8_pkg.sv
// Shared definitions for the lit_base8 base-side literal driver:
// variable encoding, FSM state type and a small decode helper.
package lit_base8_pkg;

  // Width of one packed variable: {imp, val[1:0]}
  localparam int VAR_W = 3;

  // Two-bit value encodings
  localparam logic [1:0] VAL_FREE  = 2'b00;
  localparam logic [1:0] VAL_FALSE = 2'b01;
  localparam logic [1:0] VAL_TRUE  = 2'b10;
  localparam logic [1:0] VAL_BAD   = 2'b11;

  // Driver sequencing states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_COLLECT,
    ST_DONE
  } state_t;

  // True when a value carries a definite assignment (false or true)
  function automatic logic isAssigned(input logic [1:0] v);
    return (v == VAL_FALSE) || (v == VAL_TRUE);
  endfunction

endpackage

// File: rtl/lit_base8_if.sv
// Bundle of signals between the base driver and the literal array.
// The base driver is the master; the literal array is the slave.
interface lit_base8_if
  import lit_base8_pkg::*;
#(
  parameter int NUM_LITS = 8
);

  logic                      wr_o;
  logic [NUM_LITS*VAR_W-1:0] var_value_frombase_o;
  logic                      imp_drv_o;
  logic [NUM_LITS*VAR_W-1:0] var_value_tobase_i;
  logic                      cclause_i;
  logic                      clausesat_i;

  modport master (
    output wr_o,
    output var_value_frombase_o,
    output imp_drv_o,
    input  var_value_tobase_i,
    input  cclause_i,
    input  clausesat_i
  );

  modport slave (
    input  wr_o,
    input  var_value_frombase_o,
    input  imp_drv_o,
    output var_value_tobase_i,
    output cclause_i,
    output clausesat_i
  );

endinterface

// File: rtl/lit_base8_var_merge_slot.sv
// Combinational merge of one stored variable with the value the literal
// array returned for it. Produces the updated value plus implication and
// conflict flags for the driver to accumulate.
module var_merge_slot
  import lit_base8_pkg::*;
(
  input  logic [VAR_W-1:0] i_stored,
  input  logic [VAR_W-1:0] i_returned,
  output logic [VAR_W-1:0] o_value,
  output logic             o_imp,
  output logic             o_conflict
);

  logic [1:0] w_sVal;
  logic [1:0] w_rVal;
  // The array's own imp flag carries no meaning for the merge; only its value field does
  logic       w_unusedRetImp;

  assign w_sVal         = i_stored[1:0];
  assign w_rVal         = i_returned[1:0];
  assign w_unusedRetImp = i_returned[2];

  // Decide whether the returned value implies, conflicts or is ignored
  always_comb begin
    o_value    = i_stored;
    o_imp      = 1'b0;
    o_conflict = 1'b0;
    if (w_rVal == VAL_BAD) begin
      o_conflict = 1'b1;
    end else if ((w_sVal == VAL_FREE) && isAssigned(w_rVal)) begin
      o_value = {1'b1, w_rVal};
      o_imp   = 1'b1;
    end else if (isAssigned(w_sVal) && isAssigned(w_rVal) && (w_sVal != w_rVal)) begin
      o_conflict = 1'b1;
    end
  end

endmodule

// File: rtl/lit_base8.sv
// Base-side driver for an 8-literal clause bin. Captures a snapshot of the
// variables, writes it to the literal array, holds implication drive for a
// settle window, then merges the array's returned values and reports
// implication count, conflict and clause satisfaction.
module lit_base8
  import lit_base8_pkg::*;
#(
  parameter int NUM_LITS      = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic [NUM_LITS*VAR_W-1:0]        var_value_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [NUM_LITS*VAR_W-1:0]        var_value_o,
  output logic [$clog2(NUM_LITS+1)-1:0]    imp_cnt_o,
  output logic                             conflict_o,
  output logic                             sat_o,
  lit_base8_if.master                      arr
);

  localparam int VEC_W  = NUM_LITS * VAR_W;
  localparam int CNT_W  = $clog2(NUM_LITS + 1);
  localparam int SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t              r_state;
  state_t              w_nextState;
  logic [SCNT_W-1:0]   r_settleCnt;
  logic                w_settleDone;
  logic [VEC_W-1:0]    r_vars;
  logic [VEC_W-1:0]    w_merged;
  logic [NUM_LITS-1:0] w_imp;
  logic [NUM_LITS-1:0] w_conf;
  logic [CNT_W-1:0]    w_impSum;
  logic [CNT_W-1:0]    r_impCnt;
  logic                r_conflict;
  logic                r_sat;
  logic                w_wr;
  logic                w_impDrv;
  logic                w_busy;
  logic                w_done;

  assign w_settleDone = (r_settleCnt == SCNT_W'(SETTLE_CYCLES - 1));

  // One merge slot per literal; literal 0 sits in the most significant field
  for (genvar i = 0; i < NUM_LITS; i++) begin : g_slot
    localparam int LO = VAR_W * (NUM_LITS - 1 - i);
    var_merge_slot u_slot (
      .i_stored   (r_vars[LO +: VAR_W]),
      .i_returned (arr.var_value_tobase_i[LO +: VAR_W]),
      .o_value    (w_merged[LO +: VAR_W]),
      .o_imp      (w_imp[i]),
      .o_conflict (w_conf[i])
    );
  end

  // Population count of the per-literal implication flags
  always_comb begin
    w_impSum = '0;
    for (int i = 0; i < NUM_LITS; i++) begin
      w_impSum = w_impSum + CNT_W'(w_imp[i]);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state decode and per-state strobes
  always_comb begin
    w_nextState = r_state;
    w_wr        = 1'b0;
    w_impDrv    = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start_i) w_nextState = ST_DRIVE;
      end
      ST_DRIVE: begin
        w_wr        = 1'b1;
        w_nextState = ST_SETTLE;
      end
      ST_SETTLE: begin
        w_impDrv = 1'b1;
        if (w_settleDone) w_nextState = ST_COLLECT;
      end
      ST_COLLECT: w_nextState = ST_DONE;
      ST_DONE: begin
        w_done      = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Settle window counter; rests at zero outside SETTLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_settleCnt <= '0;
    else if (r_state != ST_SETTLE) r_settleCnt <= '0;
    else if (w_settleDone)         r_settleCnt <= '0;
    else                           r_settleCnt <= r_settleCnt + SCNT_W'(1);
  end

  // Snapshot capture on accepted start, merged results on COLLECT exit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vars     <= '0;
      r_impCnt   <= '0;
      r_conflict <= 1'b0;
      r_sat      <= 1'b0;
    end else if ((r_state == ST_IDLE) && start_i) begin
      r_vars <= var_value_i;
    end else if (r_state == ST_COLLECT) begin
      r_vars     <= w_merged;
      r_impCnt   <= w_impSum;
      r_conflict <= (|w_conf) | arr.cclause_i;
      r_sat      <= arr.clausesat_i;
    end
  end

  assign busy_o                   = w_busy;
  assign done_o                   = w_done;
  assign var_value_o              = r_vars;
  assign imp_cnt_o                = r_impCnt;
  assign conflict_o               = r_conflict;
  assign sat_o                    = r_sat;
  assign arr.wr_o                 = w_wr;
  assign arr.imp_drv_o            = w_impDrv;
  assign arr.var_value_frombase_o = r_vars;

endmodule

// File: tb/tb_lit_base8.sv
// Directed testbench for lit_base8: checks reset, implication merge,
// conflict detection, flag sampling window, back-to-back runs and aborts.
module tb_lit_base8;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [23:0] var_value_i;
  logic        busy_o;
  logic        done_o;
  logic [23:0] var_value_o;
  logic [3:0]  imp_cnt_o;
  logic        conflict_o;
  logic        sat_o;

  int checks = 0;
  int errors = 0;

  lit_base8_if #(.NUM_LITS(8)) arr ();

  lit_base8 #(.NUM_LITS(8), .SETTLE_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .var_value_i (var_value_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .var_value_o (var_value_o),
    .imp_cnt_o   (imp_cnt_o),
    .conflict_o  (conflict_o),
    .sat_o       (sat_o),
    .arr         (arr)
  );

  // 10-unit clock; outputs are sampled and inputs driven on the falling edge
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present a snapshot with a one-cycle start; returns observing cycle 1
  task automatic launch(input logic [23:0] snap);
    @(negedge clk);
    var_value_i = snap;
    start_i     = 1'b1;
    @(negedge clk);
    start_i     = 1'b0;
  endtask

  // Step cycles until done_o, bounded; reports the cycle index reached
  task automatic waitDone(input int startCyc, output int cyc);
    cyc = startCyc;
    while (done_o !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_i = 1'b0;
    var_value_i = '0;
    arr.var_value_tobase_i = '0;
    arr.cclause_i = 1'b0;
    arr.clausesat_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, arr.wr_o, arr.imp_drv_o, conflict_o, sat_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {busy_o, done_o, arr.wr_o, arr.imp_drv_o, conflict_o, sat_o});
    end
    checks++;
    if (var_value_o !== 24'h0 || arr.var_value_frombase_o !== 24'h0 || imp_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_values: got var=%h frombase=%h cnt=%0d expected 0",
               var_value_o, arr.var_value_frombase_o, imp_cnt_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_implication();
    int cyc;
    arr.var_value_tobase_i = 24'h400001;
    launch(24'h000000);
    checks++;
    if (arr.wr_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_wr: got wr=%b busy=%b expected 1 1", arr.wr_o, busy_o);
    end
    waitDone(1, cyc);
    checks++;
    if (cyc !== 5 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: got cycle %0d done=%b expected cycle 5", cyc, done_o);
    end
    checks++;
    if (var_value_o !== 24'hC00005 || arr.var_value_frombase_o !== 24'hC00005) begin
      errors++;
      $display("FAIL basic_merge: got %h/%h expected c00005", var_value_o, arr.var_value_frombase_o);
    end
    checks++;
    if (imp_cnt_o !== 4'd2 || conflict_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_cnt: got cnt=%0d conf=%b expected 2 0", imp_cnt_o, conflict_o);
    end
  endtask

  task automatic test_conflict();
    int cyc;
    arr.var_value_tobase_i = 24'h001000;
    launch(24'h002000);
    waitDone(1, cyc);
    checks++;
    if (done_o !== 1'b1 || conflict_o !== 1'b1 || imp_cnt_o !== 4'd0 || var_value_o !== 24'h002000) begin
      errors++;
      $display("FAIL conflict_opposite: got done=%b conf=%b cnt=%0d var=%h expected 1 1 0 002000",
               done_o, conflict_o, imp_cnt_o, var_value_o);
    end
    arr.var_value_tobase_i = 24'h0000C0;
    launch(24'h000000);
    waitDone(1, cyc);
    checks++;
    if (done_o !== 1'b1 || conflict_o !== 1'b1 || imp_cnt_o !== 4'd0 || var_value_o !== 24'h000000) begin
      errors++;
      $display("FAIL conflict_invalid: got done=%b conf=%b cnt=%0d var=%h expected 1 1 0 000000",
               done_o, conflict_o, imp_cnt_o, var_value_o);
    end
  endtask

  task automatic test_reset_mid_settle();
    int cyc;
    int doneSeen;
    arr.var_value_tobase_i = 24'h000000;
    launch(24'h249249);
    @(negedge clk);
    checks++;
    if (arr.imp_drv_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_settle: got imp_drv=%b expected 1", arr.imp_drv_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy_o, done_o, arr.wr_o, arr.imp_drv_o, conflict_o, sat_o} !== 6'b0 ||
        var_value_o !== 24'h0 || arr.var_value_frombase_o !== 24'h0 || imp_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL abort_outputs: got flags=%b var=%h frombase=%h cnt=%0d expected all 0",
               {busy_o, done_o, arr.wr_o, arr.imp_drv_o, conflict_o, sat_o},
               var_value_o, arr.var_value_frombase_o, imp_cnt_o);
    end
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done_o === 1'b1 || busy_o === 1'b1) doneSeen++;
    end
    checks++;
    if (doneSeen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d busy/done cycles expected 0", doneSeen);
    end
    arr.var_value_tobase_i = 24'h400001;
    launch(24'h000000);
    waitDone(1, cyc);
    checks++;
    if (cyc !== 5 || var_value_o !== 24'hC00005 || imp_cnt_o !== 4'd2) begin
      errors++;
      $display("FAIL abort_recover: got cycle %0d var=%h cnt=%0d expected 5 c00005 2",
               cyc, var_value_o, imp_cnt_o);
    end
  endtask

  task automatic test_flags();
    arr.var_value_tobase_i = 24'h000000;
    launch(24'h000000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    arr.cclause_i = 1'b1;
    arr.clausesat_i = 1'b1;
    @(negedge clk);
    arr.cclause_i = 1'b0;
    arr.clausesat_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || conflict_o !== 1'b1 || sat_o !== 1'b1) begin
      errors++;
      $display("FAIL flags_collect: got done=%b conf=%b sat=%b expected 1 1 1", done_o, conflict_o, sat_o);
    end
    launch(24'h000000);
    @(negedge clk);
    arr.cclause_i = 1'b1;
    arr.clausesat_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    arr.cclause_i = 1'b0;
    arr.clausesat_i = 1'b0;
    @(negedge clk);
    checks++;
    if (done_o !== 1'b1 || conflict_o !== 1'b0 || sat_o !== 1'b0) begin
      errors++;
      $display("FAIL flags_settle: got done=%b conf=%b sat=%b expected 1 0 0", done_o, conflict_o, sat_o);
    end
  endtask

  task automatic test_back_to_back();
    int wrCnt = 0;
    int doneCnt = 0;
    int lastWr = -1;
    int spacingBad = 0;
    int cyc;
    int stray = 0;
    arr.var_value_tobase_i = 24'h000000;
    @(negedge clk);
    var_value_i = 24'h000000;
    start_i = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (arr.wr_o === 1'b1) begin
        if (lastWr >= 0 && (c - lastWr) != 6) spacingBad++;
        lastWr = c;
        wrCnt++;
      end
      if (done_o === 1'b1) doneCnt++;
    end
    start_i = 1'b0;
    checks++;
    if (wrCnt !== 4 || spacingBad !== 0 || lastWr !== 19) begin
      errors++;
      $display("FAIL b2b_wr: got %0d pulses bad=%0d last=%0d expected 4 0 19", wrCnt, spacingBad, lastWr);
    end
    checks++;
    if (doneCnt !== 3) begin
      errors++;
      $display("FAIL b2b_done: got %0d done pulses expected 3", doneCnt);
    end
    waitDone(1, cyc);
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("FAIL b2b_last_run: got cycle %0d expected 5", cyc);
    end
    launch(24'h000000);
    start_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start_i = 1'b0;
    waitDone(3, cyc);
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("FAIL ignored_start_latency: got cycle %0d expected 5", cyc);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (arr.wr_o === 1'b1 || busy_o === 1'b1) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL ignored_start_relaunch: got %0d busy cycles expected 0", stray);
    end
  endtask

  task automatic test_all_implied();
    int cyc;
    arr.var_value_tobase_i = 24'h249249;
    launch(24'h000000);
    waitDone(1, cyc);
    checks++;
    if (done_o !== 1'b1 || imp_cnt_o !== 4'd8 || var_value_o !== 24'hB6DB6D || conflict_o !== 1'b0) begin
      errors++;
      $display("FAIL all_implied: got done=%b cnt=%0d var=%h conf=%b expected 1 8 b6db6d 0",
               done_o, imp_cnt_o, var_value_o, conflict_o);
    end
  endtask

  // Run every scenario in order and print the summary
  initial begin
    $display("[TB] lit_base8 directed tests starting");
    test_reset();
    test_basic_implication();
    test_conflict();
    test_reset_mid_settle();
    test_flags();
    test_back_to_back();
    test_all_implied();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lit_base8.md
# lit_base8

Base-side driver for an 8-literal clause bin. It loads a snapshot of eight 3-bit variable values and writes them into the literal array. It then holds implication drive for a fixed settle window, collects the array's returned values, and merges them into its own registers. It reports implications, conflicts and clause satisfaction back to the bin controller. It is the counterpart of the literal array's `var_value_frombase`/`var_value_tobase` ports.

## Interface
- `NUM_LITS`, 8: literals served; must be even.
- `SETTLE_CYCLES`, 2: cycles `imp_drv_o` stays high before collection; must be ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  start request; accepted only in IDLE.
- `var_value_i`  in  NUM_LITS*3  snapshot captured on the accepted start.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse; results are valid while it is high.
- `var_value_o`  out  NUM_LITS*3  merged variable registers.
- `imp_cnt_o`  out  $clog2(NUM_LITS+1)  count of newly implied variables in the last run.
- `conflict_o`  out  1  conflict detected in the last run.
- `sat_o`  out  1  clause satisfied in the last run.
- `wr_o`  out  1  write strobe to the literal array.
- `var_value_frombase_o`  out  NUM_LITS*3  values driven to the array.
- `var_value_tobase_i`  in  NUM_LITS*3  values returned by the array.
- `imp_drv_o`  out  1  implication drive enable.
- `cclause_i`  in  1  conflict-clause flag from the array.
- `clausesat_i`  in  1  clause-satisfied flag from the array.

## Operation
- Variable encoding is `{imp, val[1:0]}`:
  - `val`: 00 free, 01 false, 10 true, 11 invalid.
  - `imp`: 1 means the value was set by implication.
- Field i occupies bits `[3*(NUM_LITS-1-i)+2 : 3*(NUM_LITS-1-i)]`. Literal 0 is the MSB field.
- FSM states are IDLE, DRIVE, SETTLE, COLLECT, DONE.
  - IDLE → DRIVE on `start_i`. `var_value_i` is captured into the registers on the same edge.
  - DRIVE: `wr_o`=1 for exactly one cycle → SETTLE.
  - SETTLE: `imp_drv_o`=1. The settle counter runs SETTLE_CYCLES cycles → COLLECT.
  - COLLECT: one cycle. The merge result, `imp_cnt_o`, `conflict_o` and `sat_o` register on exit → DONE.
  - DONE: `done_o`=1 for one cycle → IDLE.
- `var_value_frombase_o` always equals the registers (combinational).
- Per-literal merge in COLLECT, with stored value s and returned value r:
  - s.val==00 and r.val in {01,10}: register ← {1, r.val}; counts as one implication.
  - s.val in {01,10} and r.val in {01,10} and s.val≠r.val: register unchanged; raises conflict.
  - r.val==11: raises conflict; register unchanged.
  - All other cases: register unchanged.
- `conflict_o` = OR of the per-literal conflicts OR `cclause_i` sampled in COLLECT.
- `sat_o` = `clausesat_i` sampled in COLLECT.
- `imp_cnt_o` = number of implications this run (0..NUM_LITS); it never wraps.
- `start_i` outside IDLE is ignored; there is no queueing. A start held high re-launches on the first IDLE cycle after DONE.
- Result outputs hold until the next COLLECT exit.

## Timing
- Start sampled at cycle 0. DRIVE is cycle 1, SETTLE is cycles 2..1+S, COLLECT is cycle 2+S, `done_o` is cycle 3+S. With the default S=2, `done_o` is at cycle 5.
- Back-to-back: the next start can be accepted in the cycle after DONE. Run period is 4+S cycles.
- Reset (asynchronous, at any point): state → IDLE, all registers → 0, settle counter → 0. Every output is 0, including `var_value_frombase_o`. A run in progress is aborted with no `done_o`.
- `var_value_tobase_i`, `cclause_i` and `clausesat_i` are sampled only in COLLECT. Glitches in other states have no effect.

## Structure
- Shared package holds:
  - encoding constants `VAL_FREE`/`VAL_FALSE`/`VAL_TRUE`/`VAL_BAD`
  - the FSM state typedef
  - `VAR_W`=3
- Sub-module `var_merge_slot`: combinational per-literal merge, with outputs new value, `imp`, `conflict`.
  - Instantiated NUM_LITS times by a generate loop.
  - The top holds the FSM, settle counter, popcount and registers.

## Test plan
- Reset mid-SETTLE → all outputs 0, no `done_o`. A later start completes normally.
- Snapshot all free (0x000000); array returns literal 0 = 010 and literal 7 = 001, others 000 → `done_o` at cycle 5. Literal 0 = 110, literal 7 = 101, `imp_cnt_o`=2, `conflict_o`=0.
- Snapshot literal 3 = 010; array returns literal 3 = 001 → `conflict_o`=1, literal 3 still 010, `imp_cnt_o`=0.
- Array returns all 000 with `cclause_i`=1 and `clausesat_i`=1 in COLLECT only → `conflict_o`=1, `sat_o`=1. The same flags asserted only in SETTLE → both 0.
- `start_i` held high continuously → `wr_o` pulses every 6 cycles and exactly one `done_o` per run. Starts pulsed during DRIVE/SETTLE are ignored.
- Array returns all eight literals as 001 from an all-free snapshot → `imp_cnt_o`=8, all fields 101.
